// File: rtl/ooop_types.sv
// Shared out-of-order pipeline types: physical register and ROB tag
// widths, the renamed micro-op bundle and the issue bundle.
package ooop_types;

  localparam int PREG_W    = 6;
  localparam int ROB_TAG_W = 5;
  localparam int PAYLOAD_W = 16;

  typedef struct packed {
    logic [PREG_W-1:0]    prs1;
    logic [PREG_W-1:0]    prs2;
    logic                 rs1_rdy;
    logic                 rs2_rdy;
    logic [PAYLOAD_W-1:0] payload;
  } rename_pkt_t;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [PREG_W-1:0]    prs1;
    logic [PREG_W-1:0]    prs2;
    logic [ROB_TAG_W-1:0] rob_tag;
  } issue_pkt_t;

endpackage

// File: rtl/rs_oldest_select.sv
// Age-matrix picker: grants the eligible entry that has no eligible
// entry older than itself.
module rs_oldest_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]            elig_i,
  input  logic [DEPTH-1:0][DEPTH-1:0] older_i,
  output logic [DEPTH-1:0]            grant_o,
  output logic                        any_o
);

  // col[i][j] set when entry j is older than entry i
  logic [DEPTH-1:0][DEPTH-1:0] col;

  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    for (genvar j = 0; j < DEPTH; j++) begin : g_col
      assign col[i][j] = older_i[j][i];
    end
    assign grant_o[i] = elig_i[i] & ~|(elig_i & col[i]);
  end

  assign any_o = |elig_i;

endmodule

// File: rtl/rs_age_select.sv
// Reservation station: multi-port wakeup CAM, lowest-free allocation
// and oldest-ready issue via an allocation-age matrix.
module rs_age_select
  import ooop_types::*;
#(
  parameter int DEPTH      = 8,
  parameter int WAKE_PORTS = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush_i,
  input  logic                                 push_valid_i,
  output logic                                 push_ready_o,
  input  rename_pkt_t                          push_pkt_i,
  input  logic [ROB_TAG_W-1:0]                 push_rob_tag_i,
  input  logic [WAKE_PORTS-1:0]                wakeup_valid_i,
  input  logic [WAKE_PORTS-1:0][PREG_W-1:0]    wakeup_tag_i,
  input  logic                                 exec_ready_i,
  output logic                                 issue_valid_o,
  output issue_pkt_t                           issue_pkt_o,
  output logic [$clog2(DEPTH):0]               count_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0]                 valid_q, valid_d;
  logic [DEPTH-1:0]                 r1_q, r1_d;
  logic [DEPTH-1:0]                 r2_q, r2_d;
  logic [DEPTH-1:0][PREG_W-1:0]     prs1_q, prs1_d;
  logic [DEPTH-1:0][PREG_W-1:0]     prs2_q, prs2_d;
  logic [DEPTH-1:0][PAYLOAD_W-1:0]  pay_q, pay_d;
  logic [DEPTH-1:0][ROB_TAG_W-1:0]  rob_q, rob_d;
  logic [DEPTH-1:0][DEPTH-1:0]      older_q, older_d;
  logic [CW-1:0]                    cnt_q, cnt_d;

  logic [DEPTH-1:0] elig;
  logic [DEPTH-1:0] grant;
  logic [DEPTH-1:0] alloc;
  logic             any_elig;
  logic             push_fire;
  logic             pop;

  function automatic logic hit(
    input logic [PREG_W-1:0]                 tag,
    input logic [WAKE_PORTS-1:0]             v,
    input logic [WAKE_PORTS-1:0][PREG_W-1:0] t
  );
    hit = 1'b0;
    for (int p = 0; p < WAKE_PORTS; p++) begin
      hit = hit | (v[p] && (t[p] == tag));
    end
  endfunction

  assign elig = valid_q & r1_q & r2_q;

  rs_oldest_select #(
    .DEPTH (DEPTH)
  ) u_sel (
    .elig_i  (elig),
    .older_i (older_q),
    .grant_o (grant),
    .any_o   (any_elig)
  );

  assign push_ready_o  = (cnt_q < CW'(DEPTH)) && !rst;
  assign push_fire     = push_valid_i && push_ready_o && !flush_i;
  assign issue_valid_o = any_elig && !flush_i && !rst;
  assign pop           = issue_valid_o && exec_ready_i;
  assign count_o       = cnt_q;

  always_comb begin
    alloc = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        alloc    = '0;
        alloc[i] = 1'b1;
      end
    end
  end

  always_comb begin
    issue_pkt_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        issue_pkt_o.payload = pay_q[i];
        issue_pkt_o.prs1    = prs1_q[i];
        issue_pkt_o.prs2    = prs2_q[i];
        issue_pkt_o.rob_tag = rob_q[i];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    prs1_d  = prs1_q;
    prs2_d  = prs2_q;
    pay_d   = pay_q;
    rob_d   = rob_q;
    older_d = older_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        r1_d[i] = r1_q[i] | hit(prs1_q[i], wakeup_valid_i, wakeup_tag_i);
        r2_d[i] = r2_q[i] | hit(prs2_q[i], wakeup_valid_i, wakeup_tag_i);
      end
      if (pop && grant[i]) begin
        valid_d[i] = 1'b0;
      end
      // allocation targets an invalid slot, so it never collides with pop
      if (push_fire && alloc[i]) begin
        valid_d[i] = 1'b1;
        prs1_d[i]  = push_pkt_i.prs1;
        prs2_d[i]  = push_pkt_i.prs2;
        pay_d[i]   = push_pkt_i.payload;
        rob_d[i]   = push_rob_tag_i;
        r1_d[i]    = push_pkt_i.rs1_rdy |
                     hit(push_pkt_i.prs1, wakeup_valid_i, wakeup_tag_i);
        r2_d[i]    = push_pkt_i.rs2_rdy |
                     hit(push_pkt_i.prs2, wakeup_valid_i, wakeup_tag_i);
        for (int j = 0; j < DEPTH; j++) begin
          older_d[i][j] = 1'b0;
          older_d[j][i] = valid_q[j];
        end
      end
    end
    if (flush_i) begin
      valid_d = '0;
    end
  end

  always_comb begin
    cnt_d = cnt_q + CW'(push_fire) - CW'(pop);
    if (flush_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    r1_q    <= r1_d;
    r2_q    <= r2_d;
    prs1_q  <= prs1_d;
    prs2_q  <= prs2_d;
    pay_q   <= pay_d;
    rob_q   <= rob_d;
    older_q <= older_d;
  end

endmodule
